id_decode_stage_pipelined: RTL

Parametrised next-generation instruction-decode stage for the 5-stage MIPS-style pipeline. It contains the register file with write-back bypass, control decode, and in-ID branch/jump resolution. It also owns the ID/EX pipeline register, internal load-use and branch-operand hazard detection with stall/bubble insertion, and a saturating stall-cycle counter. It sits between the IF/ID register (driven by the fetch stage) and the EX stage, and receives write-back from MEM/WB.

---
 rtl/id_pkg.sv | 83 ++++++++
 rtl/id_decode_stage_pipelined_regfile_bypass.sv | 36 +++
 rtl/id_decode_stage_pipelined.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/id_pkg.sv
// Shared opcode map, ALU-op encodings and ID/EX control bundle for the decode stage.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_OP_MEM   = 2'b00;
  localparam logic [1:0] ALU_OP_BR    = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  typedef struct packed {
    ctrl_t ctrl;
    logic  reg_dst;
    logic  rt_src;
    logic  is_beq;
    logic  is_bne;
    logic  is_jump;
  } dec_t;

  // Unknown opcodes fall through as valid instructions with every control low.
  function automatic dec_t decode(input logic [5:0] opcode, input logic bne_en);
    dec_t d;
    d = '0;
    case (opcode)
      OP_RTYPE: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_op    = ALU_OP_RTYPE;
        d.reg_dst        = 1'b1;
        d.rt_src         = 1'b1;
      end
      OP_LW: begin
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.mem_read   = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.alu_op     = ALU_OP_MEM;
      end
      OP_SW: begin
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.mem_write = 1'b1;
        d.ctrl.alu_op    = ALU_OP_MEM;
        d.rt_src         = 1'b1;
      end
      OP_ADDI: begin
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_op    = ALU_OP_MEM;
      end
      OP_BEQ: begin
        d.ctrl.alu_op = ALU_OP_BR;
        d.rt_src      = 1'b1;
        d.is_beq      = 1'b1;
      end
      OP_BNE: begin
        if (bne_en) begin
          d.ctrl.alu_op = ALU_OP_BR;
          d.rt_src      = 1'b1;
          d.is_bne      = 1'b1;
        end
      end
      OP_J:    d.is_jump = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_decode_stage_pipelined_regfile_bypass.sv
// Register file with two combinational read ports, write-first bypass and r0 tied to zero.
module regfile_bypass
  import id_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [REG_ADDR_WIDTH-1:0] raddr1,
  input  logic [REG_ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0]     rdata1,
  output logic [DATA_WIDTH-1:0]     rdata2
);

  localparam int DEPTH = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 :
                  (we && (waddr == raddr1)) ? wdata : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 :
                  (we && (waddr == raddr2)) ? wdata : mem[raddr2];

endmodule

// File: rtl/id_decode_stage_pipelined.sv
// Instruction-decode stage: register read with WB bypass, control decode, in-ID branch/jump
// resolution, load-use / branch-operand stall logic and the ID/EX pipeline register.
module id_decode_stage_pipelined
  import id_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int PC_WIDTH        = 10,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter bit BNE_EN          = 1'b1,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_id_valid,
  input  logic [PC_WIDTH-1:0]        pc_plus4,
  input  logic [31:0]                instr,
  input  logic                       wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0]  wb_write_reg_addr,
  input  logic [DATA_WIDTH-1:0]      wb_write_data,
  output logic                       stall,
  output logic                       flush_if,
  output logic                       branch_taken,
  output logic [PC_WIDTH-1:0]        branch_target,
  output logic                       jump,
  output logic [PC_WIDTH-1:0]        jump_target,
  output logic                       ex_valid,
  output logic [DATA_WIDTH-1:0]      ex_reg1,
  output logic [DATA_WIDTH-1:0]      ex_reg2,
  output logic [DATA_WIDTH-1:0]      ex_imm,
  output logic [REG_ADDR_WIDTH-1:0]  ex_rs,
  output logic [REG_ADDR_WIDTH-1:0]  ex_rt,
  output logic [REG_ADDR_WIDTH-1:0]  ex_dest_reg,
  output logic                       ex_mem_to_reg,
  output logic                       ex_mem_read,
  output logic                       ex_mem_write,
  output logic                       ex_alu_src,
  output logic                       ex_reg_write,
  output logic [1:0]                 ex_alu_op,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  logic [5:0]                 opcode;
  logic [REG_ADDR_WIDTH-1:0]  rs_idx, rt_idx, rd_idx, dest_idx;
  logic signed [15:0]         imm16;
  logic signed [DATA_WIDTH-1:0] imm_ext;
  logic [PC_WIDTH-1:0]        br_off;
  logic [DATA_WIDTH-1:0]      rdata1, rdata2;
  dec_t                       dec;
  logic                       rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic                       load_use, branch_hz, is_branch, operands_eq;

  logic                       vld_p1;
  ctrl_t                      ctrl_p1;
  logic [DATA_WIDTH-1:0]      reg1_p1, reg2_p1, imm_p1;
  logic [REG_ADDR_WIDTH-1:0]  rs_p1, rt_p1, dest_p1;
  logic                       mem_reg_write_p2;
  logic [REG_ADDR_WIDTH-1:0]  mem_dest_p2;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_p1;

  assign opcode   = instr[31:26];
  assign rs_idx   = REG_ADDR_WIDTH'(instr[25:21]);
  assign rt_idx   = REG_ADDR_WIDTH'(instr[20:16]);
  assign rd_idx   = REG_ADDR_WIDTH'(instr[15:11]);
  assign imm16    = instr[15:0];
  assign imm_ext  = DATA_WIDTH'(imm16);
  assign dec      = decode(opcode, BNE_EN);
  assign dest_idx = dec.reg_dst ? rd_idx : rt_idx;

  regfile_bypass #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_reg_write),
    .waddr  (wb_write_reg_addr),
    .wdata  (wb_write_data),
    .raddr1 (rs_idx),
    .raddr2 (rt_idx),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // Source matching against the instruction in EX and its MEM shadow; r0 never conflicts.
  assign rs_hit_ex  = (dest_p1 != '0) && (dest_p1 == rs_idx);
  assign rt_hit_ex  = dec.rt_src && (dest_p1 != '0) && (dest_p1 == rt_idx);
  assign rs_hit_mem = (mem_dest_p2 != '0) && (mem_dest_p2 == rs_idx);
  assign rt_hit_mem = dec.rt_src && (mem_dest_p2 != '0) && (mem_dest_p2 == rt_idx);

  assign is_branch = dec.is_beq || dec.is_bne;
  assign load_use  = if_id_valid && ctrl_p1.mem_read && (rs_hit_ex || rt_hit_ex);
  assign branch_hz = if_id_valid && is_branch &&
                     ((ctrl_p1.reg_write && (rs_hit_ex || rt_hit_ex)) ||
                      (mem_reg_write_p2 && (rs_hit_mem || rt_hit_mem)));
  assign stall     = load_use || branch_hz;

  assign operands_eq   = (rdata1 == rdata2);
  assign branch_taken  = if_id_valid && !stall &&
                         ((dec.is_beq && operands_eq) || (dec.is_bne && !operands_eq));
  assign jump          = if_id_valid && !stall && dec.is_jump;
  assign flush_if      = branch_taken || jump;

  assign br_off        = PC_WIDTH'(imm_ext) << 2;
  assign branch_target = pc_plus4 + br_off;
  assign jump_target   = {instr[PC_WIDTH-3:0], 2'b00};

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (reset || stall || !if_id_valid) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= BUBBLE;
      reg1_p1 <= '0;
      reg2_p1 <= '0;
      imm_p1  <= '0;
      rs_p1   <= '0;
      rt_p1   <= '0;
      dest_p1 <= '0;
    end else begin
      vld_p1  <= 1'b1;
      ctrl_p1 <= dec.ctrl;
      reg1_p1 <= rdata1;
      reg2_p1 <= rdata2;
      imm_p1  <= imm_ext;
      rs_p1   <= rs_idx;
      rt_p1   <= rt_idx;
      dest_p1 <= dest_idx;
    end
  end

  // ---- EX -> MEM shadow boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_reg_write_p2 <= 1'b0;
      mem_dest_p2      <= '0;
    end else begin
      mem_reg_write_p2 <= ctrl_p1.reg_write;
      mem_dest_p2      <= dest_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_p1 <= '0;
    end else if (stall && (stall_cnt_p1 != '1)) begin
      stall_cnt_p1 <= stall_cnt_p1 + 1'b1;
    end
  end

  assign ex_valid      = vld_p1;
  assign ex_reg1       = reg1_p1;
  assign ex_reg2       = reg2_p1;
  assign ex_imm        = imm_p1;
  assign ex_rs         = rs_p1;
  assign ex_rt         = rt_p1;
  assign ex_dest_reg   = dest_p1;
  assign ex_mem_to_reg = ctrl_p1.mem_to_reg;
  assign ex_mem_read   = ctrl_p1.mem_read;
  assign ex_mem_write  = ctrl_p1.mem_write;
  assign ex_alu_src    = ctrl_p1.alu_src;
  assign ex_reg_write  = ctrl_p1.reg_write;
  assign ex_alu_op     = ctrl_p1.alu_op;
  assign stall_cycles  = stall_cnt_p1;

endmodule
